// File: rtl/iob_ptfloat_unpack_pkg.sv
// Shared definitions for the pt-float unpack block: default geometry and
// helpers that derive the unpacked exponent/mantissa widths.
package iob_ptfloat_unpack_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefEwW   = 4;

  // Widest exponent the EW field can describe: 2^EW_W-1 bits.
  function automatic int unsigned exp_max_w(input int unsigned ew_w);
    return (32'd1 << ew_w) - 32'd1;
  endfunction

  // Everything below the EW field; the mantissa is left-aligned into this.
  function automatic int unsigned man_max_w(input int unsigned data_w, input int unsigned ew_w);
    return data_w - ew_w;
  endfunction

endpackage

// File: rtl/iob_ptfloat_field_extract.sv
// Combinational field split of a pt-float body: the top ew bits are the
// exponent (sign-extended), the remaining bits are the mantissa, left-aligned.
module iob_ptfloat_field_extract
  import iob_ptfloat_unpack_pkg::*;
#(
  parameter  int unsigned DATA_W    = DefDataW,
  parameter  int unsigned EW_W      = DefEwW,
  localparam int unsigned EXP_MAX_W = exp_max_w(EW_W),
  localparam int unsigned MAN_MAX_W = man_max_w(DATA_W, EW_W),
  localparam int unsigned SH_W      = $clog2(MAN_MAX_W + 1)
) (
  input  logic [MAN_MAX_W-1:0] body_i,
  input  logic [EW_W-1:0]      ew_i,
  output logic [EXP_MAX_W-1:0] exp_o,
  output logic [MAN_MAX_W-1:0] man_o
);

  logic [SH_W-1:0] w_ew;
  logic [SH_W-1:0] w_mw;

  assign w_ew = {{(SH_W - EW_W){1'b0}}, ew_i};
  assign w_mw = SH_W'(MAN_MAX_W) - w_ew;

  // Arithmetic right shift by the mantissa width leaves the exponent field
  // sign-extended in the low bits; ew=0 has no exponent field at all.
  assign exp_o = (ew_i == '0) ? '0 : EXP_MAX_W'($signed(body_i) >>> w_mw);

  // Shifting left by ew pushes the exponent out and MSB-aligns the mantissa.
  assign man_o = body_i << w_ew;

endmodule

// File: rtl/iob_ptfloat_unpack.sv
// Registered pt-float unpack: one word in per start, exponent and aligned
// mantissa out one cycle later with done.
module iob_ptfloat_unpack
  import iob_ptfloat_unpack_pkg::*;
#(
  parameter  int unsigned DATA_W    = DefDataW,
  parameter  int unsigned EW_W      = DefEwW,
  localparam int unsigned EXP_MAX_W = exp_max_w(EW_W),
  localparam int unsigned MAN_MAX_W = man_max_w(DATA_W, EW_W)
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic                 start_i,
  output logic                 done_o,
  input  logic [DATA_W-1:0]    data_i,
  output logic [EXP_MAX_W-1:0] exp_o,
  output logic [MAN_MAX_W-1:0] man_o
);

  logic [EXP_MAX_W-1:0] w_exp;
  logic [MAN_MAX_W-1:0] w_man;
  logic                 r_done;
  logic [EXP_MAX_W-1:0] r_exp;
  logic [MAN_MAX_W-1:0] r_man;

  iob_ptfloat_field_extract #(
    .DATA_W(DATA_W),
    .EW_W  (EW_W)
  ) u_field_extract (
    .body_i(data_i[MAN_MAX_W-1:0]),
    .ew_i  (data_i[DATA_W-1 -: EW_W]),
    .exp_o (w_exp),
    .man_o (w_man)
  );

  // Output and done registers; reset wins over cke, cke=0 freezes everything.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_done <= 1'b0;
      r_exp  <= '0;
      r_man  <= '0;
    end else if (cke_i) begin
      r_done <= start_i;
      if (start_i) begin
        r_exp <= w_exp;
        r_man <= w_man;
      end
    end
  end

  assign done_o = r_done;
  assign exp_o  = r_exp;
  assign man_o  = r_man;

endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// Scoreboard bench for iob_ptfloat_unpack (DATA_W=32, EW_W=4).
module tb_iob_ptfloat_unpack;

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 15;
  localparam int unsigned MW = 28;

  typedef struct {
    string         name;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic          cke_i = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          done_o;
  logic [EW-1:0] exp_o;
  logic [MW-1:0] man_o;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  logic fresh = 1'b0;

  iob_ptfloat_unpack #(
    .DATA_W(DW),
    .EW_W  (4)
  ) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .start_i(start_i),
    .done_o (done_o),
    .data_i (data_i),
    .exp_o  (exp_o),
    .man_o  (man_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Marks edges on which the outputs may have taken new values.
  always @(posedge clk_i) fresh <= cke_i && !arst_i;

  // Monitor: every fresh done pops one expected result.
  always @(negedge clk_i) begin
    if (done_o && fresh) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'd0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check({x.name, "_exp"}, 64'(exp_o), 64'(x.e));
        check({x.name, "_man"}, 64'(man_o), 64'(x.m));
      end
    end
  end

  task automatic send(input string name, input logic [DW-1:0] d, input logic [EW-1:0] e,
                      input logic [MW-1:0] m);
    exp_t x;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    data_i  = d;
    x.name  = name;
    x.e     = e;
    x.m     = m;
    sb_q.push_back(x);
  endtask

  task automatic idle();
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    // Reset held 100 cycles, with start asserted to show reset overrides it.
    arst_i  = 1'b1;
    start_i = 1'b1;
    data_i  = 32'hFFFF_FFFF;
    repeat (100) @(posedge clk_i);
    #1;
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_exp", 64'(exp_o), 64'd0);
    check("rst_man", 64'(man_o), 64'd0);

    // cke low during a start: nothing moves.
    arst_i = 1'b0;
    cke_i  = 1'b0;
    @(posedge clk_i);
    #1;
    check("frz0_done", 64'(done_o), 64'd0);
    check("frz0_exp", 64'(exp_o), 64'd0);
    check("frz0_man", 64'(man_o), 64'd0);
    cke_i   = 1'b1;
    start_i = 1'b0;

    // Back-to-back words, then assorted exponent widths.
    send("v0f", 32'h0000_000f, 15'h0000, 28'h000_000f);
    send("v2000f", 32'h0002_000f, 15'h0000, 28'h002_000f);
    send("v80", 32'h8000_0000, 15'h0000, 28'h000_0000);
    send("vc1", 32'hc000_0001, 15'h0000, 28'h000_1000);
    send("va2", 32'ha000_0002, 15'h0000, 28'h000_0800);
    send("v62", 32'h6000_0002, 15'h0000, 28'h000_0080);
    send("v4f", 32'h4F00_0000, 15'h7FFF, 28'h000_0000);

    // Freeze with done high: new data must not load, done must stay 1.
    @(posedge clk_i);
    #1;
    cke_i   = 1'b0;
    start_i = 1'b1;
    data_i  = 32'h0002_000f;
    @(posedge clk_i);
    #1;
    check("frz1_done", 64'(done_o), 64'd1);
    check("frz1_exp", 64'(exp_o), 64'h7FFF);
    check("frz1_man", 64'(man_o), 64'h000_0000);
    cke_i   = 1'b1;
    start_i = 1'b0;

    send("vff", 32'hFFFF_FFFF, 15'h7FFF, 28'hFFF_8000);
    idle();
    @(posedge clk_i);
    #1;
    check("drop_done", 64'(done_o), 64'd0);
    check("drop_exp", 64'(exp_o), 64'h7FFF);
    check("drop_man", 64'(man_o), 64'hFFF_8000);

    // Reset mid-stream.
    send("vc1b", 32'hc000_0001, 15'h0000, 28'h000_1000);
    @(posedge clk_i);
    #1;
    arst_i  = 1'b1;
    start_i = 1'b1;
    data_i  = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    check("mrst_done", 64'(done_o), 64'd0);
    check("mrst_exp", 64'(exp_o), 64'd0);
    check("mrst_man", 64'(man_o), 64'd0);
    arst_i  = 1'b0;
    start_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
